// File: rtl/bp_pkg.sv
// Shared types and index/counter helpers for the two-level branch predictor.
package bp_pkg;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

    // hash != 0: xor of history with low word-PC bits; otherwise history concatenated above PC bits.
    function automatic logic [31:0] pht_index(input logic [31:0] hist, input logic [31:0] pc,
                                              input int hash, input int hist_w, input int pc_bits);
        logic [31:0] word_pc;
        word_pc = pc >> 2;
        if (hash != 0)
            return (hist ^ word_pc) & ((32'd1 << hist_w) - 32'd1);
        else
            return (hist << pc_bits) | (word_pc & ((32'd1 << pc_bits) - 32'd1));
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] ctr, input int ctr_w);
        logic [31:0] ctr_max;
        ctr_max = (32'd1 << ctr_w) - 32'd1;
        return (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] ctr);
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Generic table: one combinational read port, one write port whose current contents
// are read back combinationally, and a sweep-init port that wins over the write port.
module bp_table #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              init_en,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    assign rd_data = mem_q[rd_addr];
    assign rb_data = mem_q[wr_addr];

    always_ff @(posedge clk) begin
        if (init_en)
            mem_q[init_addr] <= init_data;
        else if (wr_en)
            mem_q[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/bht_two_level_predictor.sv
// Two-level local branch predictor: per-branch history rows select a saturating counter.
//   state | meaning
//   INIT  | sweeping both tables to their init values, ready low
//   RUN   | tables valid, predictions and updates live
module bht_two_level_predictor
    import bp_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int HIST_W    = 4,
    parameter int CTR_W     = 2,
    parameter int PC_BITS   = 2,
    parameter int HASH      = 0,
    parameter int CTR_INIT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    output logic              ready,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken
);

    localparam int PHT_IDX_W = (HASH != 0) ? HIST_W : HIST_W + PC_BITS;
    localparam int SWEEP_W   = (BHT_IDX_W > PHT_IDX_W) ? BHT_IDX_W : PHT_IDX_W;

    state_e             state_q, state_d;
    logic [SWEEP_W-1:0] cnt_q, cnt_d;

    logic                 init_en;
    logic                 upd_en;
    logic [HIST_W-1:0]    rd_hist;
    logic [HIST_W-1:0]    upd_hist;
    logic [CTR_W-1:0]     rd_ctr;
    logic [CTR_W-1:0]     upd_ctr;
    logic [CTR_W-1:0]     new_ctr;
    logic [PHT_IDX_W-1:0] rd_pht_idx;
    logic [PHT_IDX_W-1:0] upd_pht_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = RUN;
            end
            RUN: begin
                if (flush) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready   = (state_q == RUN);
    assign init_en = (state_q == INIT);
    // An update coinciding with flush is dropped along with the rest of the table state.
    assign upd_en  = ready & upd_valid & ~flush;

    assign rd_pht_idx  = PHT_IDX_W'(pht_index(32'(rd_hist), 32'(pred_pc), HASH, HIST_W, PC_BITS));
    assign upd_pht_idx = PHT_IDX_W'(pht_index(32'(upd_hist), 32'(upd_pc), HASH, HIST_W, PC_BITS));
    assign new_ctr     = upd_taken ? CTR_W'(sat_inc(32'(upd_ctr), CTR_W))
                                   : CTR_W'(sat_dec(32'(upd_ctr)));

    assign pred_hist  = ready ? rd_hist : '0;
    assign pred_taken = ready & rd_ctr[CTR_W-1];

    bp_table #(.ADDR_W(BHT_IDX_W), .DATA_W(HIST_W)) u_bht (
        .clk       (clk),
        .rd_addr   (pred_pc[BHT_IDX_W+1:2]),
        .rd_data   (rd_hist),
        .wr_en     (upd_en),
        .wr_addr   (upd_pc[BHT_IDX_W+1:2]),
        .wr_data   ({upd_hist[HIST_W-2:0], upd_taken}),
        .rb_data   (upd_hist),
        .init_en   (init_en),
        .init_addr (cnt_q[BHT_IDX_W-1:0]),
        .init_data ('0)
    );

    bp_table #(.ADDR_W(PHT_IDX_W), .DATA_W(CTR_W)) u_pht (
        .clk       (clk),
        .rd_addr   (rd_pht_idx),
        .rd_data   (rd_ctr),
        .wr_en     (upd_en),
        .wr_addr   (upd_pht_idx),
        .wr_data   (new_ctr),
        .rb_data   (upd_ctr),
        .init_en   (init_en),
        .init_addr (cnt_q[PHT_IDX_W-1:0]),
        .init_data (CTR_W'(CTR_INIT))
    );

endmodule
